match_count_uart_tx: RTL and testbench
======================================

# match_count_uart_tx

Consumer and transmitter for the bitwise pipeline's result stream. Each valid strobe from the pipeline captures the 32-bit EF match count into a small FIFO. Each buffered word is then sent off-chip as four UART 8N1 frames, least-significant byte first. The block sits directly after the `pipelining` unit and is the only path by which match counts leave the device.

## Interface

- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, 4: word capacity of the capture FIFO. Must be a power of two and at least 2.
- `i_clk` input 1: single clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_valid` input 1: capture strobe, driven by the pipeline's `valid_out`.
- `i_match_count` input 32: data word, driven by the pipeline's `EF_match_count`. Sampled only when `i_valid` is 1.
- `o_tx` output 1: UART serial line, idles high.
- `o_busy` output 1: 1 when the FSM is not in IDLE or the FIFO is non-empty.
- `o_overflow` output 1: sticky flag, set when a capture is dropped because the FIFO is full.
- `o_fifo_level` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.

## Operation

- Reset (asynchronous, while `i_rst_n` is 0):
  - `o_tx`=1, `o_busy`=0, `o_overflow`=0, `o_fifo_level`=0.
  - FSM goes to IDLE; all counters and pointers are cleared.
  - Asserting reset mid-frame aborts the frame: `o_tx` goes high immediately and all buffered words are discarded.
- Capture: on a rising edge with `i_valid`=1, write `i_match_count` into the FIFO.
  - The write is accepted if level < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the word is dropped, `o_overflow` is set to 1 and stays set until reset, and the level is unchanged.
- Simultaneous push and pop: both happen and the level is unchanged. This applies at full as well as at any other level.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `o_tx`=1. If level > 0, pop the head word into a 32-bit shift register, set byte index to 0 and go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `o_tx` = bit[bit index] of the current byte for CLKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles. Then:
    - if byte index < 3, increment byte index and go directly to START (no idle gap between the bytes of one word);
    - otherwise go to IDLE.
- Byte order: the bytes of a word are sent as [7:0], [15:8], [23:16], [31:24].
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit transition;
  - its width is $clog2(CLKS_PER_BIT) bits.
- `o_tx` is registered, with no combinational path from the inputs.

## Timing

- First bit latency, with FIFO empty and FSM in IDLE:
  - `i_valid` sampled at edge N;
  - pop at edge N+1;
  - `o_tx` falls in the cycle after edge N+1.
- Each word occupies 40×CLKS_PER_BIT cycles on the line.
- Back-to-back words are separated by exactly 1 IDLE cycle with `o_tx`=1.
- `o_fifo_level` updates in the cycle after the push or pop edge.
- `o_busy` is registered/derived from state and level and follows them by at most 0 extra cycles: it must rise in the cycle after the accepted push edge.
- `o_overflow` rises in the cycle after the dropping edge.
- Sustained throughput is limited to 1 word per (40×CLKS_PER_BIT+1) cycles. Faster `i_valid` rates fill the FIFO and then set overflow.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- Reset values: hold `i_rst_n`=0 for 3 cycles, then release.
  - Required: `o_tx`=1, `o_busy`=0, `o_overflow`=0, `o_fifo_level`=0.
  - Required: the line stays idle for 200 cycles with no `i_valid`.
- Single word: pulse `i_valid` once with 32'hA5C3_0F81.
  - Required: the serial decoder receives bytes 0x81, 0x0F, 0xC3, 0xA5 in that order.
  - Required: the start bit of byte 0 begins 2 cycles after the capture edge.
  - Required: the transmission lasts 160 cycles, after which `o_busy` returns to 0.
- Back-to-back words: pulse `i_valid` on 3 consecutive cycles with 1, 2, 3.
  - Required: `o_fifo_level` peaks at 2 (the first word is popped immediately).
  - Required: 12 bytes are decoded in order.
  - Required: exactly 1 idle-high cycle separates the words.
- Overflow: hold `i_valid`=1 for 10 consecutive cycles with the values 0..9.
  - Required: words 0..4 are transmitted (1 in flight plus 4 buffered).
  - Required: `o_overflow`=1 from the cycle after the first dropped word and remains set after the line drains.
- Push and pop at full: fill the FIFO to 4, then pulse `i_valid` on the same edge as the IDLE pop.
  - Required: the word is accepted, the level stays 4, and `o_overflow` stays 0.
- Reset mid-frame: assert `i_rst_n`=0 during DATA bit 3 of byte 1.
  - Required: `o_tx`=1 asynchronously and the level is 0.
  - Required: after release with no new `i_valid`, no further bytes are emitted.

Source files
------------

// File: rtl/match_count_uart_tx.sv
// match_count_uart_tx: buffers 32-bit match counts from the pipeline in a small
// FIFO and sends each word off-chip as four UART 8N1 frames, LSB byte first.
module match_count_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [31:0]                   i_match_count,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          overflow;
    logic          push, pop;

    state_t        state, state_d;
    logic [CW-1:0] baud, baud_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [1:0]    byte_idx, byte_idx_d;
    logic [31:0]   shreg, shreg_d;
    logic          tx_q, tx_d;
    logic          baud_done;
    logic [2:0]    next_bit;

    // The FSM only pops from IDLE; a push is still accepted at full when a pop
    // frees a slot on the same edge.
    assign pop       = (state == IDLE) && (level != '0);
    assign push      = i_valid && ((level != FULL) || pop);
    assign baud_done = (baud == BAUD_LAST);
    assign next_bit  = bit_idx + 3'd1;

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_match_count;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (i_valid && !push) overflow <= 1'b1;
        end
    end

    // Transmitter state register; o_tx comes straight from a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud     <= baud_d;
            bit_idx  <= bit_idx_d;
            byte_idx <= byte_idx_d;
            shreg    <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level for the cycle after the edge,
    // so the start bit appears one edge after the pop.
    always_comb begin
        state_d    = state;
        baud_d     = baud;
        bit_idx_d  = bit_idx;
        byte_idx_d = byte_idx;
        shreg_d    = shreg;
        tx_d       = tx_q;
        case (state)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (pop) begin
                    shreg_d    = mem[rd_ptr];
                    byte_idx_d = 2'd0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shreg[0];
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = next_bit;
                        tx_d      = shreg[next_bit];
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_idx != 2'd3) begin
                        // Next byte of the same word follows with no idle gap.
                        byte_idx_d = byte_idx + 2'd1;
                        shreg_d    = {8'h00, shreg[31:8]};
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_tx         = tx_q;
    assign o_busy       = (state != IDLE) || (level != '0);
    assign o_overflow   = overflow;
    assign o_fifo_level = level;

endmodule

// File: tb/tb_match_count_uart_tx.sv
// Directed bench for match_count_uart_tx with an independent 8N1 line decoder.
module tb_match_count_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data  = '0;
    logic        tx, busy, ovf;
    logic [2:0]  level;

    match_count_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid),
        .i_match_count (data),
        .o_tx          (tx),
        .o_busy        (busy),
        .o_overflow    (ovf),
        .o_fifo_level  (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pk    = 0;
    int c     = 0;

    // posedge counter used as the time base for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // line decoder: sample each bit in its second cycle
    logic [7:0] rx_q[$];
    int         st_q[$];
    int         n_frm = 0;
    bit         d_act = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_sh  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (tx === 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
                st_q.push_back(cyc);
            end
        end else begin
            d_cnt++;
            if (d_cnt >= 5 && d_cnt <= 33 && ((d_cnt - 5) % 4) == 0)
                d_sh[3'((d_cnt - 5) / 4)] = tx;
            if (d_cnt == 37 && tx !== 1'b1) n_frm++;
            if (d_cnt == 38) begin
                rx_q.push_back(d_sh);
                d_act = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        rx_q.delete();
        st_q.delete();
        rst_n = 1'b1;
    endtask

    // wait for the line to drain, tracking peak FIFO level; bounded
    task automatic drain(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < budget) begin
            if (int'(level) > pk) pk = int'(level);
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx),    32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_bytes", 32'(rx_q.size() + st_q.size()), 32'd0);
        chk("idle_tx",    32'(tx),   32'd1);
        chk("idle_busy",  32'(busy), 32'd0);

        // single word
        c     = cyc;
        valid = 1'b1;
        data  = 32'hA5C3_0F81;
        @(negedge clk);
        valid = 1'b0;
        chk("sw_level1", 32'(level), 32'd1);
        chk("sw_busy1",  32'(busy),  32'd1);
        chk("sw_tx_hi",  32'(tx),    32'd1);
        @(negedge clk);
        chk("sw_tx_lo",  32'(tx),    32'd0);
        chk("sw_level0", 32'(level), 32'd0);
        wait_cyc(c + 161);
        chk("sw_busy_end", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sw_busy_off", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("sw_nbytes", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            chk("sw_b0", 32'(rx_q[0]), 32'h81);
            chk("sw_b1", 32'(rx_q[1]), 32'h0F);
            chk("sw_b2", 32'(rx_q[2]), 32'hC3);
            chk("sw_b3", 32'(rx_q[3]), 32'hA5);
            chk("sw_start_lat", 32'(st_q[0] - c), 32'd2);
            chk("sw_byte_gap",  32'(st_q[1] - st_q[0]), 32'd40);
        end
        rx_q.delete();
        st_q.delete();

        // back-to-back words 1,2,3
        pk = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (int'(level) > pk) pk = int'(level);
            valid = 1'b1;
            data  = 32'(i + 1);
        end
        @(negedge clk);
        valid = 1'b0;
        drain(3 * 161 + 40);
        chk("b2b_peak",   32'(pk), 32'd2);
        chk("b2b_nbytes", 32'(rx_q.size()), 32'd12);
        if (rx_q.size() == 12) begin
            for (int k = 0; k < 12; k++)
                chk("b2b_byte", 32'(rx_q[k]), (k % 4 == 0) ? 32'(k / 4 + 1) : 32'd0);
            chk("b2b_gap01", 32'(st_q[4] - st_q[3]), 32'd41);
            chk("b2b_gap12", 32'(st_q[8] - st_q[7]), 32'd41);
        end
        rx_q.delete();
        st_q.delete();

        // overflow: ten consecutive captures 0..9
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("ovf_pre",     32'(ovf),   32'd0);
                chk("ovf_full_lv", 32'(level), 32'd4);
            end
            if (i == 6) chk("ovf_set", 32'(ovf), 32'd1);
            valid = 1'b1;
            data  = 32'(i);
        end
        @(negedge clk);
        valid = 1'b0;
        chk("ovf_level_held", 32'(level), 32'd4);
        drain(5 * 161 + 40);
        chk("ovf_nbytes", 32'(rx_q.size()), 32'd20);
        if (rx_q.size() == 20) begin
            for (int k = 0; k < 5; k++)
                chk("ovf_word", 32'(rx_q[4 * k]), 32'(k));
        end
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // push and pop on the same edge at full
        reset_dut();
        chk("pp_ovf_rst", 32'(ovf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) c = cyc;
            valid = 1'b1;
            data  = 32'(100 + i);
        end
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(c + 162);
        chk("pp_full_pre", 32'(level), 32'd4);
        valid = 1'b1;
        data  = 32'd105;
        @(negedge clk);
        valid = 1'b0;
        chk("pp_full_post", 32'(level), 32'd4);
        chk("pp_no_ovf",    32'(ovf),   32'd0);
        drain(5 * 161 + 40);
        chk("pp_nbytes", 32'(rx_q.size()), 32'd24);
        if (rx_q.size() == 24) chk("pp_last_word", 32'(rx_q[20]), 32'd105);

        // reset during DATA bit 3 of byte 1
        reset_dut();
        @(negedge clk);
        c     = cyc;
        valid = 1'b1;
        data  = 32'h1234_0055;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(c + 59);
        chk("mid_tx_low", 32'(tx), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_tx_async", 32'(tx),    32'd1);
        chk("mid_level",    32'(level), 32'd0);
        chk("mid_busy",     32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("mid_nbytes", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) chk("mid_byte0", 32'(rx_q[0]), 32'h55);
        chk("mid_idle_tx", 32'(tx), 32'd1);

        chk("framing", 32'(n_frm), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
